mario_sprite_fetch: RTL and testbench
=====================================

# mario_sprite_fetch

Per-pixel sprite fetch stage that sits directly upstream of the Mario sprite ROMs (one 20×22-pixel, 12-bit-palette ROM per animation frame, read combinationally by a 9-bit `read_address`). From the VGA scan position and Mario's position and motion flags, it:

- computes the ROM address, with horizontal mirroring for left-facing Mario;
- runs the walk-animation state machine that selects which frame ROM to use;
- registers the returned colour with a transparency flag for the downstream colour mapper.

## Interface

Parameters:

- `SPR_W`, 20, sprite width in pixels
- `SPR_H`, 22, sprite height in pixels
- `ANIM_DIV`, 6, frame_ticks per walk frame (≥1)

Ports:

- `Clk`  in  1  pixel clock; all state rising-edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `frame_tick`  in  1  one-cycle pulse per video frame (during vblank)
- `pix_valid`  in  1  DrawX/DrawY is a visible pixel this cycle
- `DrawX`  in  10  scan column, 0..639
- `DrawY`  in  10  scan row, 0..479
- `MarioX`  in  10  sprite top-left column
- `MarioY`  in  10  sprite top-left row
- `moving`  in  1  horizontal velocity non-zero
- `airborne`  in  1  Mario not on ground
- `facing_left`  in  1  mirror sprite horizontally
- `read_address`  out  9  ROM address, row-major dy*SPR_W+col
- `sprite_sel`  out  3  frame ROM select: 0 stand, 1/2/3 walk, 4 jump
- `color_in`  in  12  ROM output for current `read_address`/`sprite_sel` (combinational)
- `sprite_color`  out  12  registered sprite colour
- `sprite_opaque`  out  1  registered: pixel inside sprite and not transparent

## Operation

Animation FSM:

- States: STAND, WALK1, WALK2, WALK3, JUMP. The state directly drives `sprite_sel` (0, 1, 2, 3, 4).
- The FSM and the divider `anim_cnt` (width ceil(log2(ANIM_DIV))+1) change only on cycles with `frame_tick`=1.
- Transitions on `frame_tick`, in priority order:
  - `airborne` → JUMP, `anim_cnt`=0.
  - else `!moving` → STAND, `anim_cnt`=0.
  - else from STAND or JUMP → WALK1, `anim_cnt`=0.
  - else in WALKn: if `anim_cnt`==ANIM_DIV-1, advance WALK1→WALK2→WALK3→WALK1 and set `anim_cnt`=0; otherwise `anim_cnt`+1.
- `facing_left` is not part of the FSM. It is sampled per pixel in stage 1.

Stage 1 (registered from DrawX/DrawY):

- `dx` = DrawX−MarioX and `dy` = DrawY−MarioY, 11-bit two's complement.
- `in_box` = `pix_valid` & 0≤dx<SPR_W & 0≤dy<SPR_H.
- `col` = `facing_left` ? SPR_W−1−dx : dx.
- `read_address` ← `in_box` ? dy*SPR_W+col : 0. The maximum is SPR_W*SPR_H−1 = 439; no wrap.
- `hit1` ← `in_box`.

Stage 2 (registered from the combinational ROM return):

- `sprite_color` ← `hit1` ? `color_in` : 12'h000.
- `sprite_opaque` ← `hit1` & (`color_in` ≠ 12'h808). 12'h808 is the transparent key.

Boundary conditions:

- If the sprite box extends past column 639 or row 479, only on-screen pixels hit. No wrap to column 0.
- When MarioX > DrawX, `dx` is negative, so `in_box`=0.
- If `frame_tick` coincides with a stage-1 pixel, that pixel uses the post-tick `sprite_sel`. This is harmless because ticks occur in vblank.
- `moving` and `airborne` changing between ticks have no effect until the next tick.

Reset (asynchronous, `Reset_n`=0):

- FSM → STAND and `anim_cnt`=0.
- `read_address`=0, `sprite_sel`=0, `hit1`=0, `sprite_color`=0, `sprite_opaque`=0.
- Reset mid-line or mid-animation discards all pipeline contents. The first valid output follows 2 cycles after release.

## Timing

- Latency: DrawX/DrawY at edge N → `read_address`/`sprite_sel` valid after edge N+1 → `sprite_color`/`sprite_opaque` valid after edge N+2.
- The ROM must be combinational within one cycle. `color_in` is sampled at edge N+2.
- Throughput: one pixel per clock, no stalls, no handshake. `pix_valid`=0 simply forces a miss.
- FSM update: `sprite_sel` changes one cycle after the `frame_tick` edge. A walk frame persists for exactly ANIM_DIV ticks.

## Test plan

- **Reset:** hold `Reset_n`=0 for 3 cycles, then release.
  - All outputs must be 0 and `sprite_sel`=0.
  - Assert `Reset_n`=0 mid-walk (WALK2): `sprite_sel` must read 0 immediately, with no clock edge needed.
- **Address, right-facing:** MarioX=100, MarioY=50, `facing_left`=0. Scan row 53, columns 99..121.
  - `read_address`=0 with `hit1`=0 at X=99.
  - `read_address`=60..79 for X=100..119.
  - Miss at X=120.
  - Each result appears 1 cycle after its DrawX.
- **Mirror and transparency:**
  - Same position with `facing_left`=1: X=100 → addr 79; X=119 → addr 60.
  - Drive `color_in`=12'h808 → `sprite_opaque`=0. Drive `color_in`=12'hF30 → `sprite_opaque`=1 and `sprite_color`=F30, 2 cycles after DrawX.
- **Animation:** ANIM_DIV=6, `moving`=1, `airborne`=0. Apply 20 frame_ticks.
  - `sprite_sel` sequence: 1 for 6 ticks, 2 for 6, 3 for 6, then 1.
  - `moving`=0 → 0 on the next tick.
  - `airborne`=1 with `moving`=1 → 4.
  - Landing with `moving`=1 → restarts at 1 with a full 6-tick dwell.
- **Screen edge:** MarioX=630, MarioY=470.
  - Only X=630..639 and Y=470..479 produce hits.
  - Max address check: pixel (649, 491) is unreachable. Pixel (639, 479) gives addr 9*20+9=189.
  - With MarioX=620, MarioY=458, pixel (639, 479) gives addr 439.
  - `pix_valid`=0 inside the box forces a miss.

Source files
------------

// File: rtl/mario_sprite_fetch.sv
// Per-pixel Mario sprite fetch: ROM address generation with horizontal mirroring,
// walk-animation frame select, and registered colour/opacity for the colour mapper.
module mario_sprite_fetch #(
    parameter int SPR_W    = 20,
    parameter int SPR_H    = 22,
    parameter int ANIM_DIV = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        pix_valid,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  MarioX,
    input  logic [9:0]  MarioY,
    input  logic        moving,
    input  logic        airborne,
    input  logic        facing_left,
    output logic [8:0]  read_address,
    output logic [2:0]  sprite_sel,
    input  logic [11:0] color_in,
    output logic [11:0] sprite_color,
    output logic        sprite_opaque
);

    localparam int CNT_W = $clog2(ANIM_DIV) + 1;

    localparam logic [2:0] ST_STAND = 3'd0;
    localparam logic [2:0] ST_WALK1 = 3'd1;
    localparam logic [2:0] ST_WALK2 = 3'd2;
    localparam logic [2:0] ST_WALK3 = 3'd3;
    localparam logic [2:0] ST_JUMP  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST        = CNT_W'(ANIM_DIV - 1);
    localparam logic [11:0]      TRANSPARENT_KEY = 12'h808;

    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] anim_cnt_reg, anim_cnt_next;

    // Animation only advances on frame ticks; motion flags in between are ignored.
    always_comb begin
        state_next    = state_reg;
        anim_cnt_next = anim_cnt_reg;
        if (frame_tick) begin
            if (airborne) begin
                state_next    = ST_JUMP;
                anim_cnt_next = '0;
            end else if (!moving) begin
                state_next    = ST_STAND;
                anim_cnt_next = '0;
            end else if (state_reg == ST_STAND || state_reg == ST_JUMP) begin
                state_next    = ST_WALK1;
                anim_cnt_next = '0;
            end else if (anim_cnt_reg == CNT_LAST) begin
                anim_cnt_next = '0;
                case (state_reg)
                    ST_WALK1: state_next = ST_WALK2;
                    ST_WALK2: state_next = ST_WALK3;
                    default:  state_next = ST_WALK1;
                endcase
            end else begin
                anim_cnt_next = anim_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= ST_STAND;
            anim_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            anim_cnt_reg <= anim_cnt_next;
        end
    end

    assign sprite_sel = state_reg;

    // Offsets are 11-bit two's complement so a pixel left of/above Mario goes negative.
    logic [10:0] dx, dy;
    logic        in_box;
    logic [8:0]  col, addr_calc;

    assign dx        = {1'b0, DrawX} - {1'b0, MarioX};
    assign dy        = {1'b0, DrawY} - {1'b0, MarioY};
    assign in_box    = pix_valid && !dx[10] && (dx < 11'(SPR_W))
                                 && !dy[10] && (dy < 11'(SPR_H));
    assign col       = facing_left ? (9'(SPR_W - 1) - dx[8:0]) : dx[8:0];
    assign addr_calc = dy[8:0] * 9'(SPR_W) + col;

    logic hit1_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= '0;
            hit1_reg     <= 1'b0;
        end else begin
            read_address <= in_box ? addr_calc : 9'd0;
            hit1_reg     <= in_box;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sprite_color  <= 12'h000;
            sprite_opaque <= 1'b0;
        end else begin
            sprite_color  <= hit1_reg ? color_in : 12'h000;
            sprite_opaque <= hit1_reg && (color_in != TRANSPARENT_KEY);
        end
    end

endmodule

// File: tb/tb_mario_sprite_fetch.sv
// Scoreboard bench for mario_sprite_fetch: pixels push expected address/colour,
// which are popped one and two cycles later as the pipeline delivers them.
module tb_mario_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_tick;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY, MarioX, MarioY;
    logic        moving, airborne, facing_left;
    logic [8:0]  read_address;
    logic [2:0]  sprite_sel;
    logic [11:0] color_in;
    logic [11:0] sprite_color;
    logic        sprite_opaque;

    logic        force_en;
    logic [11:0] force_color;

    int n_vec = 0;
    int n_err = 0;
    int model_sel = 0;

    typedef struct {
        int          x;
        int          y;
        logic [8:0]  addr;
        logic [11:0] color;
        logic        opaque;
    } exp_t;

    exp_t addr_q[$];
    exp_t col_q[$];

    mario_sprite_fetch #(.SPR_W(20), .SPR_H(22), .ANIM_DIV(6)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .MarioX(MarioX), .MarioY(MarioY),
        .moving(moving), .airborne(airborne), .facing_left(facing_left),
        .read_address(read_address), .sprite_sel(sprite_sel), .color_in(color_in),
        .sprite_color(sprite_color), .sprite_opaque(sprite_opaque)
    );

    always #5 Clk = ~Clk;

    // Combinational ROM stand-in: frame select and address are both visible in the colour.
    assign color_in = force_en ? force_color : {sprite_sel, read_address};

    task automatic step(input bit drive, input int x, input int y, input bit v);
        exp_t e;
        int dxi, dyi, c;
        bit hit;
        @(negedge Clk);
        if (col_q.size() > 0) begin
            e = col_q.pop_front();
            n_vec++;
            if (sprite_color !== e.color || sprite_opaque !== e.opaque) begin
                n_err++;
                $display("FAIL color (%0d,%0d): got color=%h opaque=%b, want color=%h opaque=%b",
                         e.x, e.y, sprite_color, sprite_opaque, e.color, e.opaque);
            end
        end
        if (addr_q.size() > 0) begin
            e = addr_q.pop_front();
            n_vec++;
            if (read_address !== e.addr) begin
                n_err++;
                $display("FAIL addr (%0d,%0d): got %0d, want %0d", e.x, e.y, read_address, e.addr);
            end
            col_q.push_back(e);
        end
        if (drive) begin
            DrawX = 10'(x);
            DrawY = 10'(y);
            pix_valid = v;
            dxi = x - int'(MarioX);
            dyi = y - int'(MarioY);
            hit = v && dxi >= 0 && dxi < 20 && dyi >= 0 && dyi < 22;
            c = facing_left ? 19 - dxi : dxi;
            e.x = x;
            e.y = y;
            e.addr = hit ? 9'(dyi * 20 + c) : 9'd0;
            if (!hit) e.color = 12'h000;
            else if (force_en) e.color = force_color;
            else e.color = {3'(model_sel), e.addr};
            e.opaque = hit && (e.color != 12'h808);
            addr_q.push_back(e);
        end else begin
            pix_valid = 1'b0;
        end
    endtask

    task automatic drain();
        while (addr_q.size() > 0 || col_q.size() > 0) step(0, 0, 0, 0);
    endtask

    task automatic scan(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) step(1, x, y, 1);
        drain();
    endtask

    task automatic tick();
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        n_vec++;
        if (read_address !== 9'd0 || sprite_sel !== 3'd0 || sprite_color !== 12'h000 || sprite_opaque !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got addr=%0d sel=%0d color=%h opaque=%b, want all 0",
                     read_address, sprite_sel, sprite_color, sprite_opaque);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        n_vec++;
        if (read_address !== 9'd0 || sprite_sel !== 3'd0 || sprite_color !== 12'h000 || sprite_opaque !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got addr=%0d sel=%0d color=%h opaque=%b, want all 0",
                     read_address, sprite_sel, sprite_color, sprite_opaque);
        end
        $display("reset: checked outputs during and after reset");
    endtask

    task automatic test_address_right();
        MarioX = 10'd100; MarioY = 10'd50; facing_left = 1'b0;
        scan(53, 99, 121);
        $display("address_right: scanned row 53 cols 99..121");
    endtask

    task automatic test_mirror_transparency();
        MarioX = 10'd100; MarioY = 10'd50; facing_left = 1'b1;
        scan(53, 99, 121);
        force_en = 1'b1; force_color = 12'h808;
        scan(60, 98, 104);
        force_color = 12'hF30;
        scan(60, 98, 104);
        force_en = 1'b0;
        facing_left = 1'b0;
        $display("mirror_transparency: mirrored row and forced 808/F30 colours");
    endtask

    task automatic test_screen_edge();
        MarioX = 10'd630; MarioY = 10'd470;
        scan(469, 626, 639);
        scan(470, 626, 639);
        scan(479, 626, 639);
        scan(0, 630, 639);
        MarioX = 10'd620; MarioY = 10'd458;
        scan(479, 618, 639);
        step(1, 630, 470, 0);
        step(1, 639, 479, 0);
        drain();
        $display("screen_edge: edge rows, wrap rows and pix_valid=0 inside box");
    endtask

    task automatic test_animation();
        int exp_sel;
        moving = 1'b1; airborne = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_sel = ((k - 1) / 6) % 3 + 1;
            n_vec++;
            if (sprite_sel !== 3'(exp_sel)) begin
                n_err++;
                $display("FAIL walk tick %0d: got sel=%0d, want %0d", k, sprite_sel, exp_sel);
            end
        end
        moving = 1'b0;
        tick();
        n_vec++;
        if (sprite_sel !== 3'd0) begin
            n_err++;
            $display("FAIL stop: got sel=%0d, want 0", sprite_sel);
        end
        moving = 1'b1; airborne = 1'b1;
        tick();
        n_vec++;
        if (sprite_sel !== 3'd4) begin
            n_err++;
            $display("FAIL jump: got sel=%0d, want 4", sprite_sel);
        end
        airborne = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_sel = (k <= 6) ? 1 : 2;
            n_vec++;
            if (sprite_sel !== 3'(exp_sel)) begin
                n_err++;
                $display("FAIL land tick %0d: got sel=%0d, want %0d", k, sprite_sel, exp_sel);
            end
        end
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        n_vec++;
        if (sprite_sel !== 3'd0 || read_address !== 9'd0 || sprite_opaque !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got sel=%0d addr=%0d opaque=%b, want 0",
                     sprite_sel, read_address, sprite_opaque);
        end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        moving = 1'b0;
        $display("animation: walk cycle, stop, jump, landing dwell, mid-walk reset");
    endtask

    initial begin
        Reset_n = 1'b0; frame_tick = 1'b0; pix_valid = 1'b0;
        DrawX = '0; DrawY = '0; MarioX = '0; MarioY = '0;
        moving = 1'b0; airborne = 1'b0; facing_left = 1'b0;
        force_en = 1'b0; force_color = 12'h000;
        model_sel = 0;
        test_reset();
        test_address_right();
        test_mirror_transparency();
        test_screen_edge();
        test_animation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
